triangle_raster_scan: RTL and testbench
=======================================

Name: triangle_raster_scan

Overview:
- Sequential pixel scanner that sits directly upstream of checkPoint.
- Accepts one triangle (three vertices) per job and computes its axis-aligned bounding box.
- Sweeps every integer point (px,py) inside that box, one point per accepted cycle, and drives px/py into checkPoint. It samples checkPoint's combinational check result as chk_in.
- Emits each point with its inside flag on a valid/ready stream, counts inside points, and reports the count with a done pulse.

Parameters:
- W, 11, coordinate width (matches checkPoint's 11-bit coordinates).
- CW, 2*W+1, width of inside-point counter. Holds the full 2^W x 2^W point count.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only in IDLE.
- ax, ay, bx, by, cx, cy  in  W each  triangle vertices, unsigned; sampled on accepted start.
- px, py  out  W each  current scan point, registered; wired to checkPoint px/py.
- tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy  out  W each  latched vertices, registered; wired to checkPoint a/b/c.
- chk_in  in  1  checkPoint check output for current px/py (combinational return path).
- pix_valid  out  1  scan point presented downstream.
- pix_ready  in  1  downstream accepts point.
- pix_x, pix_y  out  W each  point coordinates (equal px, py).
- pix_in  out  1  inside flag (equals chk_in while pix_valid).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.
- inside_count  out  CW  number of points with pix_in=1 accepted in the last job.

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE.
  - px, py, tri_* = 0; inside_count = 0.
  - pix_valid, busy, done = 0.
  - Reset mid-job aborts immediately; no done pulse.
- States: IDLE, BBOX, SCAN, FIN.
- IDLE:
  - start=1 latches all six vertex inputs into tri_* and clears the internal counter.
  - Next state BBOX.
  - start in any other state is ignored; no queuing.
- BBOX (exactly 1 cycle):
  - Registers xmin/xmax = min/max(ax,bx,cx) and ymin/ymax = min/max(ay,by,cy), unsigned compare.
  - Loads px=xmin, py=ymin.
  - Next state SCAN.
- SCAN:
  - pix_valid = 1 (decoded from state). pix_x=px, pix_y=py, pix_in=chk_in.
  - Transfer occurs when pix_valid & pix_ready. On transfer, the counter increments if chk_in=1.
  - Advance on transfer, row-major, x inner:
    - If px<xmax: px+1.
    - Else if py<ymax: px=xmin, py+1.
    - Else: next state FIN.
  - With pix_ready=0, px/py/counter hold; pix_x/pix_y stay stable.
  - No wrap: xmax=2^W-1 terminates the row by comparison, never by overflow.
- FIN (1 cycle):
  - done=1.
  - inside_count loads the final count, including the last transfer.
  - Next state IDLE; busy drops in the same cycle done drops.
  - inside_count holds until the next FIN or reset.
- Latency: start accepted at cycle 0, BBOX at 1, first pix_valid at 2.
  - With pix_ready always 1, done is high at cycle 2 + N, where N = (xmax-xmin+1)*(ymax-ymin+1).
- Degenerate triangle (all vertices equal or collinear): the box still scans normally.
  - A 1x1 box emits exactly one point.
- start high in the FIN cycle: ignored (state is not IDLE). start must be held or re-asserted in IDLE to be accepted.
- Vertex inputs may change during a job; only the latched tri_* values are used.

Test Plan:
- a=(0,0), b=(4,0), c=(0,4); chk_in tied 1; pix_ready=1 -> 25 points (0,0),(1,0)..(4,4) in row-major order; done at cycle 27; inside_count=25.
- Same triangle; chk_in from a behavioural point-in-triangle model -> inside_count=15 (points with x+y<=4); each pix_in matches the model.
- a=b=c=(7,9) -> single point (7,9); done at cycle 3; inside_count=chk_in value.
- Box x 2046..2047, y 0..1; pix_ready toggled 1,0,0,1,... -> points (2046,0),(2047,0),(2046,1),(2047,1). Outputs stable while stalled; no px wrap to 0.
- RESET_N pulsed low during SCAN at point 3 -> pix_valid/busy fall immediately; no done; inside_count=0. A new start then runs a full job correctly.
- start asserted during SCAN with different vertices -> ignored; job completes with the original box.

Source files
------------

// File: rtl/triangle_raster_scan.sv
// rtl/triangle_raster_scan.sv - bounding-box raster scanner feeding checkPoint
// Latches a triangle, sweeps its bounding box row-major on a valid/ready stream, counts inside points.
module triangle_raster_scan #(
    parameter int W  = 11,
    parameter int CW = 2*W+1
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    input  logic          start,
    input  logic [W-1:0]  ax,
    input  logic [W-1:0]  ay,
    input  logic [W-1:0]  bx,
    input  logic [W-1:0]  by,
    input  logic [W-1:0]  cx,
    input  logic [W-1:0]  cy,
    output logic [W-1:0]  px,
    output logic [W-1:0]  py,
    output logic [W-1:0]  tri_ax,
    output logic [W-1:0]  tri_ay,
    output logic [W-1:0]  tri_bx,
    output logic [W-1:0]  tri_by,
    output logic [W-1:0]  tri_cx,
    output logic [W-1:0]  tri_cy,
    input  logic          chk_in,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [W-1:0]  pix_x,
    output logic [W-1:0]  pix_y,
    output logic          pix_in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] inside_count
);

    typedef enum logic [1:0] {IDLE, BBOX, SCAN, FIN} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   xmin, xmax, ymin, ymax;
    logic [W-1:0]   bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           xfer, row_end, col_end;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    assign bb_xmin = min3(tri_ax, tri_bx, tri_cx);
    assign bb_xmax = max3(tri_ax, tri_bx, tri_cx);
    assign bb_ymin = min3(tri_ay, tri_by, tri_cy);
    assign bb_ymax = max3(tri_ay, tri_by, tri_cy);

    // Row/column ends are found by comparison so a box touching 2^W-1 never wraps.
    assign row_end = !(px < xmax);
    assign col_end = !(py < ymax);
    assign xfer    = pix_valid & pix_ready;
    assign cnt_nxt = cnt + {{(CW-1){1'b0}}, chk_in};

    assign pix_x  = px;
    assign pix_y  = py;
    assign pix_in = pix_valid & chk_in;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = BBOX;
            end
            BBOX: state_nxt = SCAN;
            SCAN: begin
                pix_valid = 1'b1;
                if (pix_ready && row_end && col_end) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            px <= '0; py <= '0;
            tri_ax <= '0; tri_ay <= '0; tri_bx <= '0;
            tri_by <= '0; tri_cx <= '0; tri_cy <= '0;
            xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
            cnt <= '0; inside_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    tri_ax <= ax; tri_ay <= ay; tri_bx <= bx;
                    tri_by <= by; tri_cx <= cx; tri_cy <= cy;
                    cnt    <= '0;
                end
                BBOX: begin
                    xmin <= bb_xmin; xmax <= bb_xmax;
                    ymin <= bb_ymin; ymax <= bb_ymax;
                    px   <= bb_xmin; py   <= bb_ymin;
                end
                SCAN: if (xfer) begin
                    cnt <= cnt_nxt;
                    if (!row_end) begin
                        px <= px + 1'b1;
                    end else if (!col_end) begin
                        px <= xmin;
                        py <= py + 1'b1;
                    end else begin
                        // Published on the final transfer so it is valid while done is high.
                        inside_count <= cnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_raster_scan.sv
// tb/tb_triangle_raster_scan.sv - self-checking bench for triangle_raster_scan
// Table of jobs plus reset-abort sequence; expected points flow through a scoreboard queue.
module tb_triangle_raster_scan;
    localparam int W  = 11;
    localparam int CW = 2*W+1;

    logic CLOCK_50 = 1'b0;
    logic RESET_N, start, chk_in, pix_valid, pix_ready, pix_in, busy, done;
    logic [W-1:0] ax, ay, bx, by, cx, cy, px, py, pix_x, pix_y;
    logic [W-1:0] tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy;
    logic [CW-1:0] inside_count;

    always #5 CLOCK_50 = ~CLOCK_50;

    triangle_raster_scan #(.W(W), .CW(CW)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .px(px), .py(py),
        .tri_ax(tri_ax), .tri_ay(tri_ay), .tri_bx(tri_bx),
        .tri_by(tri_by), .tri_cx(tri_cx), .tri_cy(tri_cy),
        .chk_in(chk_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_in(pix_in),
        .busy(busy), .done(done), .inside_count(inside_count)
    );

    function automatic bit in_tri(int x, int y, int x0, int y0, int x1, int y1, int x2, int y2);
        int e0, e1, e2;
        e0 = (x1-x0)*(y-y0) - (y1-y0)*(x-x0);
        e1 = (x2-x1)*(y-y1) - (y2-y1)*(x-x1);
        e2 = (x0-x2)*(y-y2) - (y0-y2)*(x-x2);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    // checkPoint stand-in: 0 = tied 1, 1 = geometric model, 2 = tied 0
    int chk_mode = 0;
    assign chk_in = (chk_mode == 0) ? 1'b1 : (chk_mode == 2) ? 1'b0 :
                    in_tri(int'(px), int'(py), int'(tri_ax), int'(tri_ay),
                           int'(tri_bx), int'(tri_by), int'(tri_cx), int'(tri_cy));

    typedef struct {
        int ax, ay, bx, by, cx, cy;
        int chk;        // chk_mode for this job
        int rdy;        // 0 always ready, 1 pattern 1,0,0,1, 2 random
        bit restart;    // assert start with other vertices mid-scan
        int exp_count;  // -1: use scoreboard model total
        int exp_cyc;    // 0: not checked
    } vec_t;

    typedef struct { int x, y; bit in; } pt_t;

    pt_t  q[$];
    vec_t tbl[7];
    int   vectors = 0;
    int   errs    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int abort_at);
        int xmin, xmax, ymin, ymax, sum, cyc, xfers, k, sx, sy;
        bit r, stalled, fin;
        pt_t e;
        bit pat[4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        xmin = (v.ax < v.bx) ? v.ax : v.bx; xmin = (v.cx < xmin) ? v.cx : xmin;
        xmax = (v.ax > v.bx) ? v.ax : v.bx; xmax = (v.cx > xmax) ? v.cx : xmax;
        ymin = (v.ay < v.by) ? v.ay : v.by; ymin = (v.cy < ymin) ? v.cy : ymin;
        ymax = (v.ay > v.by) ? v.ay : v.by; ymax = (v.cy > ymax) ? v.cy : ymax;
        sum = 0;
        for (int y = ymin; y <= ymax; y++)
            for (int x = xmin; x <= xmax; x++) begin
                e.x = x; e.y = y;
                e.in = (v.chk == 0) ? 1'b1 : (v.chk == 2) ? 1'b0 :
                       in_tri(x, y, v.ax, v.ay, v.bx, v.by, v.cx, v.cy);
                sum += int'(e.in);
                q.push_back(e);
            end

        @(negedge CLOCK_50);
        chk_mode = v.chk;
        ax = W'(v.ax); ay = W'(v.ay); bx = W'(v.bx);
        by = W'(v.by); cx = W'(v.cx); cy = W'(v.cy);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        cyc = 1; xfers = 0; k = 0; stalled = 0; sx = 0; sy = 0; fin = 0;
        for (int t = 0; t < 20000; t++) begin
            @(negedge CLOCK_50);
            if (done) begin fin = 1; break; end
            if (abort_at >= 0 && xfers == abort_at) begin
                RESET_N = 1'b0;
                #1;
                check("abort_pix_valid", pix_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_inside_count", inside_count, 0);
                q.delete();
                @(negedge CLOCK_50);
                RESET_N = 1'b1;
                return;
            end
            if (v.restart) begin
                start = (cyc == 5);
                if (cyc == 5) begin ax = 0; ay = 0; bx = 9; by = 9; cx = 0; cy = 9; end
            end
            r = (v.rdy == 0) ? 1'b1 : (v.rdy == 1) ? pat[k % 4] : 1'(($urandom_range(0, 1)));
            k++;
            pix_ready = r;
            check("busy_in_job", busy, 1);
            if (stalled) begin
                check("stall_x", pix_x, sx);
                check("stall_y", pix_y, sy);
            end
            stalled = 0;
            if (pix_valid) begin
                check("pix_x_eq_px", pix_x, px);
                if (r) begin
                    if (q.size() == 0) begin
                        check("unexpected_point", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("pix_x", pix_x, e.x);
                        check("pix_y", pix_y, e.y);
                        check("pix_in", pix_in, e.in);
                    end
                    xfers++;
                end else begin
                    stalled = 1; sx = int'(pix_x); sy = int'(pix_y);
                end
            end
            @(posedge CLOCK_50);
            cyc++;
        end
        check("done_seen", fin, 1);
        if (v.exp_cyc > 0) check("done_cycle", cyc, v.exp_cyc);
        check("points_left", q.size(), 0);
        check("inside_count", inside_count, (v.exp_count >= 0) ? v.exp_count : sum);
        check("tri_ax", tri_ax, v.ax);
        check("tri_cy", tri_cy, v.cy);
        pix_ready = 1'b1;
        @(negedge CLOCK_50);
        check("done_pulse_len", done, 0);
        check("busy_after", busy, 0);
        check("count_hold", inside_count, (v.exp_count >= 0) ? v.exp_count : sum);
        q.delete();
    endtask

    initial begin
        tbl[0] = '{ax:0, ay:0, bx:4, by:0, cx:0, cy:4, chk:0, rdy:0, restart:0, exp_count:25, exp_cyc:27};
        tbl[1] = '{ax:0, ay:0, bx:4, by:0, cx:0, cy:4, chk:1, rdy:0, restart:0, exp_count:15, exp_cyc:27};
        tbl[2] = '{ax:7, ay:9, bx:7, by:9, cx:7, cy:9, chk:0, rdy:0, restart:0, exp_count:1,  exp_cyc:3};
        tbl[3] = '{ax:7, ay:9, bx:7, by:9, cx:7, cy:9, chk:2, rdy:0, restart:0, exp_count:0,  exp_cyc:3};
        tbl[4] = '{ax:2046, ay:0, bx:2047, by:1, cx:2046, cy:1, chk:1, rdy:1, restart:0, exp_count:3, exp_cyc:0};
        tbl[5] = '{ax:1, ay:2, bx:3, by:2, cx:1, cy:3, chk:0, rdy:0, restart:1, exp_count:6, exp_cyc:8};
        tbl[6] = '{ax:10, ay:5, bx:2, by:8, cx:6, cy:1, chk:1, rdy:2, restart:0, exp_count:-1, exp_cyc:0};

        RESET_N = 1'b0; start = 1'b0; pix_ready = 1'b1;
        ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_px", px, 0);
        check("rst_py", py, 0);
        check("rst_tri_bx", tri_bx, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_inside_count", inside_count, 0);
        RESET_N = 1'b1;

        for (int i = 0; i < 7; i++) run_job(tbl[i], -1);
        run_job(tbl[0], 3);
        run_job(tbl[1], -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
